pdm_cic_stereo_decim: RTL
=========================

// Module: pdm_cic_stereo_decim
// PURPOSE
//  Stereo PDM-to-PCM decimator. Generalised CIC: N stages, decimation R, derived internal width.
//  Samples one shared PDM data pin on en_left / en_right strobes from the audio clock generator.
//  Per-channel integrator chains run at PDM rate. One shared, time-multiplexed comb engine
//  (single subtractor, FSM) runs once per R sample pairs.
//  Emits rounded signed PCM words with a one-cycle valid strobe and a sticky overrun flag.
// PARAMETERS
//  N      3   CIC order (integrator and comb stages per channel), 1..6
//  R      32  decimation ratio in sample pairs, >=2
//  W_OUT  16  PCM output width, W_OUT <= W
//  (local) W = 2 + N*$clog2(R), internal accumulator width; SHIFT = W - W_OUT
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high
//  pdm_din    in   1      shared PDM data pin
//  en_left    in   1      one-cycle strobe: sample pdm_din into left chain
//  en_right   in   1      one-cycle strobe: sample pdm_din into right chain, advances decimation count
//  pcm_left   out  W_OUT  signed left PCM word, held until next update
//  pcm_right  out  W_OUT  signed right PCM word, held until next update
//  pcm_valid  out  1      one-cycle pulse: pcm_left/pcm_right just updated
//  overrun    out  1      sticky: a decimation trigger was dropped (engine busy)
// BEHAVIOUR
//  Reset:
//   - All integrators, comb delays, accumulators, dcnt and PCM outputs are cleared to 0.
//   - pcm_valid=0, overrun=0, FSM=IDLE. Strobes in the reset cycle are ignored.
//   - Reset mid-computation aborts the pass; no pcm_valid follows.
//  Input mapping: pdm_din=1 -> +1, pdm_din=0 -> -1, sign-extended to W.
//  Integrators, per channel, on that channel's strobe:
//   - I0 <= I0 + x; Ik <= Ik + I(k-1) using the old register values (pipelined).
//   - W-bit two's-complement wrap is intended; no saturation anywhere in the chain.
//  en_left and en_right in the same cycle: both chains update independently.
//  Decimation counter dcnt (0..R-1):
//   - Increments on en_right; wraps at R-1.
//   - en_right with dcnt==R-1 is a trigger at cycle t.
//  FSM:
//   - IDLE: on trigger -> CAPTURE.
//   - CAPTURE (t+1): acc_l <= I(N-1)_left, acc_r <= I(N-1)_right. Both include the R-th pair.
//   - COMB (t+2 .. t+2N+1): step s=0..2N-1. s<N: left stage s, else right stage s-N.
//     Each step: d = acc - dly[ch][k]; dly[ch][k] <= acc; acc <= d. All W-bit wrap arithmetic.
//   - OUT (t+2N+2): pcm_* <= (acc + 2^(SHIFT-1)) >>> SHIFT. The rounding term is omitted if SHIFT==0.
//     pcm_valid=1 in cycle t+2N+3 only. -> IDLE.
//  Range: |acc| <= R^N <= 2^(W-2), so rounding cannot overflow W_OUT; no clipping logic.
//  Trigger while FSM != IDLE:
//   - The trigger is dropped and overrun <= 1, held until reset.
//   - Integrators and dcnt keep running.
//   - The next accepted pass uses current integrator values.
//  Min trigger spacing for lossless operation: 2N+3 clk.
//  DC gain R^N / 2^SHIFT: N=3, R=32, W_OUT=16 -> W=17, SHIFT=1, full scale +/-16384.
// TESTING (N=3, R=32, W_OUT=16 unless stated)
//  1. pdm_din=1 at every strobe, 20 x 32 pairs -> after 3rd pcm_valid, pcm_left=pcm_right=+16384 on every pulse.
//  2. pdm_din=0 at every strobe -> settles to pcm_left=pcm_right=-16384.
//  3. Left strobes see 1, right strobes see 0 -> pcm_left=+16384, pcm_right=-16384. No cross-talk.
//  4. Per-channel 1,0,1,0 pattern -> settled pcm_left=pcm_right=0. pcm_valid every 32 en_right strobes,
//     exactly 2N+3=9 clk after the trigger strobe.
//  5. R=2, en_right every 4 clk -> overrun=1 after the 2nd trigger, stays 1.
//     pcm_valid still pulses for accepted passes; reset clears overrun.
//  6. Reset asserted in COMB state -> no pcm_valid. pcm_left=pcm_right=0, dcnt=0.
//     After release, test 1 response reproduces exactly.

Source files
------------

// File: rtl/pdm_cic_stereo_decim_if.sv
// Stereo PDM decimator bus: PDM pin and strobes in, PCM words and status out.
// Master drives the PDM side; slave is the decimator.
interface pdm_cic_stereo_decim_if #(
    parameter int W_OUT = 16
);
    logic                    pdm_din;
    logic                    en_left;
    logic                    en_right;
    logic signed [W_OUT-1:0] pcm_left;
    logic signed [W_OUT-1:0] pcm_right;
    logic                    pcm_valid;
    logic                    overrun;

    modport master (
        output pdm_din, en_left, en_right,
        input  pcm_left, pcm_right, pcm_valid, overrun
    );

    modport slave (
        input  pdm_din, en_left, en_right,
        output pcm_left, pcm_right, pcm_valid, overrun
    );
endinterface

// File: rtl/pdm_cic_stereo_decim.sv
// Stereo PDM-to-PCM CIC decimator: per-channel integrators at PDM rate,
// one shared time-multiplexed comb engine, rounded PCM output.
module pdm_cic_stereo_decim #(
    parameter int N     = 3,
    parameter int R     = 32,
    parameter int W_OUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pdm_cic_stereo_decim_if.slave  bus
);
    localparam int W     = 2 + N * $clog2(R);
    localparam int SHIFT = W - W_OUT;
    localparam int CW    = $clog2(R);
    localparam int SW    = $clog2(2 * N);
    localparam logic [W-1:0] RND =
        (SHIFT > 0) ? (W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    typedef enum logic [1:0] {IDLE, CAPTURE, COMB, OUT} state_e;

    state_e                  state_q, state_d;
    logic [SW-1:0]           step_q, step_d;
    logic [CW-1:0]           dcnt_q;
    logic [W-1:0]            il_q [N];
    logic [W-1:0]            ir_q [N];
    logic [W-1:0]            dly_q [2*N];
    logic [W-1:0]            acc_l_q, acc_r_q;
    logic signed [W_OUT-1:0] pcm_l_q, pcm_r_q;
    logic                    valid_q, ovr_q;

    logic                    trig;
    logic                    right_step;
    logic [W-1:0]            x_in, cmb_a, cmb_d;
    logic [W-1:0]            rl_sum, rr_sum;
    logic signed [W_OUT-1:0] pcm_l_d, pcm_r_d;

    assign x_in = bus.pdm_din ? W'(1) : '1;
    assign trig = bus.en_right && (dcnt_q == CW'(R - 1));

    // Pipelined integrators: every stage adds the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                il_q[k] <= '0;
                ir_q[k] <= '0;
            end
        end else begin
            if (bus.en_left) begin
                il_q[0] <= il_q[0] + x_in;
                for (int k = 1; k < N; k++)
                    il_q[k] <= il_q[k] + il_q[k-1];
            end
            if (bus.en_right) begin
                ir_q[0] <= ir_q[0] + x_in;
                for (int k = 1; k < N; k++)
                    ir_q[k] <= ir_q[k] + ir_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            dcnt_q <= '0;
        else if (bus.en_right)
            dcnt_q <= (dcnt_q == CW'(R - 1)) ? '0 : dcnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE:    if (trig) state_d = CAPTURE;
            CAPTURE: begin
                state_d = COMB;
                step_d  = '0;
            end
            COMB: begin
                if (step_q == SW'(2 * N - 1))
                    state_d = OUT;
                else
                    step_d = step_q + SW'(1);
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delay slots are laid out so the step number indexes them directly.
    assign right_step = (step_q >= SW'(N));
    assign cmb_a      = right_step ? acc_r_q : acc_l_q;
    assign cmb_d      = cmb_a - dly_q[step_q];

    assign rl_sum  = acc_l_q + RND;
    assign rr_sum  = acc_r_q + RND;
    assign pcm_l_d = W_OUT'($signed(rl_sum) >>> SHIFT);
    assign pcm_r_d = W_OUT'($signed(rr_sum) >>> SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
            for (int k = 0; k < 2 * N; k++)
                dly_q[k] <= '0;
            pcm_l_q <= '0;
            pcm_r_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= (state_q == OUT);
            if (trig && state_q != IDLE)
                ovr_q <= 1'b1;
            unique case (1'b1)
                (state_q == CAPTURE): begin
                    acc_l_q <= il_q[N-1];
                    acc_r_q <= ir_q[N-1];
                end
                (state_q == COMB): begin
                    dly_q[step_q] <= cmb_a;
                    if (right_step)
                        acc_r_q <= cmb_d;
                    else
                        acc_l_q <= cmb_d;
                end
                (state_q == OUT): begin
                    pcm_l_q <= pcm_l_d;
                    pcm_r_q <= pcm_r_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.pcm_left  = pcm_l_q;
    assign bus.pcm_right = pcm_r_q;
    assign bus.pcm_valid = valid_q;
    assign bus.overrun   = ovr_q;
endmodule
